// File: rtl/pc_field_sequencer.sv
// Program counter with instruction-field sequencing: PC stepping, jumps, subroutine entry,
// interrupt entry with field save, deferred field changes and a PC latch.
module pc_field_sequencer #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned FIELD_W    = 3,
    parameter int unsigned RESET_PC   = 'o200,
    parameter int unsigned INT_VECTOR = 1
) (
    input  logic               CK,
    input  logic               RESET,
    input  logic [2:0]         OP,
    input  logic [WIDTH-1:0]   IN,
    input  logic [FIELD_W-1:0] FIELD_IN,
    input  logic               LD_IB,
    input  logic               LATCH,
    output logic [WIDTH-1:0]   PC,
    output logic [WIDTH-1:0]   PCLAT,
    output logic [FIELD_W-1:0] IF,
    output logic [FIELD_W-1:0] IB,
    output logic [FIELD_W-1:0] SF,
    output logic               INT_INHIBIT,
    output logic               WRAP
);

    localparam logic [2:0] OpHold = 3'd0;
    localparam logic [2:0] OpInc  = 3'd1;
    localparam logic [2:0] OpSkip = 3'd2;
    localparam logic [2:0] OpJmp  = 3'd3;
    localparam logic [2:0] OpJms  = 3'd4;
    localparam logic [2:0] OpInt  = 3'd5;
    localparam int unsigned WidthP1 = WIDTH + 1;

    logic [WIDTH-1:0]   pc_q, pc_d, pclat_q, pclat_d;
    logic [FIELD_W-1:0] if_q, if_d, ib_q, ib_d, sf_q, sf_d;
    logic               inh_q, inh_d, wrap_q, wrap_d;
    logic [WIDTH:0]     inc_sum, skip_sum;

    // Carry bit of the widened sum is the wrap indication.
    assign inc_sum  = {1'b0, pc_q} + WidthP1'(1);
    assign skip_sum = {1'b0, pc_q} + WidthP1'(2);

    always_comb begin
        pc_d    = pc_q;
        if_d    = if_q;
        ib_d    = ib_q;
        sf_d    = sf_q;
        inh_d   = inh_q;
        wrap_d  = 1'b0;
        pclat_d = LATCH ? pc_q : pclat_q;
        case (OP)
            OpHold: ;
            OpInc: begin
                pc_d   = inc_sum[WIDTH-1:0];
                wrap_d = inc_sum[WIDTH];
            end
            OpSkip: begin
                pc_d   = skip_sum[WIDTH-1:0];
                wrap_d = skip_sum[WIDTH];
            end
            OpJmp: begin
                pc_d  = IN;
                if_d  = ib_q;
                inh_d = 1'b0;
            end
            OpJms: begin
                pc_d  = IN + WIDTH'(1);
                if_d  = ib_q;
                inh_d = 1'b0;
            end
            OpInt: begin
                pc_d  = WIDTH'(INT_VECTOR);
                sf_d  = if_q;
                if_d  = '0;
                ib_d  = '0;
                inh_d = 1'b0;
            end
            default: ;
        endcase
        // Interrupt entry wins over a simultaneous buffer load.
        if (LD_IB && OP != OpInt) begin
            ib_d  = FIELD_IN;
            inh_d = 1'b1;
        end
    end

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            pc_q    <= WIDTH'(RESET_PC);
            pclat_q <= '0;
            if_q    <= '0;
            ib_q    <= '0;
            sf_q    <= '0;
            inh_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pclat_q <= pclat_d;
            if_q    <= if_d;
            ib_q    <= ib_d;
            sf_q    <= sf_d;
            inh_q   <= inh_d;
            wrap_q  <= wrap_d;
        end
    end

    assign PC          = pc_q;
    assign PCLAT       = pclat_q;
    assign IF          = if_q;
    assign IB          = ib_q;
    assign SF          = sf_q;
    assign INT_INHIBIT = inh_q;
    assign WRAP        = wrap_q;

endmodule

// File: tb/tb_pc_field_sequencer.sv
// Scoreboard bench for pc_field_sequencer: a reference model pushes expected state per cycle.
module tb_pc_field_sequencer;

    localparam int W  = 12;
    localparam int FW = 3;

    logic          CK = 1'b0;
    logic          RESET;
    logic [2:0]    OP;
    logic [W-1:0]  IN;
    logic [FW-1:0] FIELD_IN;
    logic          LD_IB, LATCH;
    logic [W-1:0]  PC, PCLAT;
    logic [FW-1:0] IF, IB, SF;
    logic          INT_INHIBIT, WRAP;

    pc_field_sequencer dut (
        .CK(CK), .RESET(RESET), .OP(OP), .IN(IN), .FIELD_IN(FIELD_IN), .LD_IB(LD_IB),
        .LATCH(LATCH), .PC(PC), .PCLAT(PCLAT), .IF(IF), .IB(IB), .SF(SF),
        .INT_INHIBIT(INT_INHIBIT), .WRAP(WRAP)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic [W-1:0]  pc;
        logic [W-1:0]  pclat;
        logic [FW-1:0] fif;
        logic [FW-1:0] ib;
        logic [FW-1:0] sf;
        logic          inh;
        logic          wrap;
    } st_t;

    st_t m;
    st_t sb_q[$];
    int  n_total = 0;
    int  n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input st_t e);
        check_eq({tag, ".PC"}, 32'(PC), 32'(e.pc));
        check_eq({tag, ".PCLAT"}, 32'(PCLAT), 32'(e.pclat));
        check_eq({tag, ".IF"}, 32'(IF), 32'(e.fif));
        check_eq({tag, ".IB"}, 32'(IB), 32'(e.ib));
        check_eq({tag, ".SF"}, 32'(SF), 32'(e.sf));
        check_eq({tag, ".INH"}, 32'(INT_INHIBIT), 32'(e.inh));
        check_eq({tag, ".WRAP"}, 32'(WRAP), 32'(e.wrap));
    endtask

    function automatic st_t reset_state();
        st_t r;
        r.pc = W'('o200); r.pclat = '0; r.fif = '0; r.ib = '0; r.sf = '0;
        r.inh = 1'b0; r.wrap = 1'b0;
        return r;
    endfunction

    // Reference next-state written directly from the operation definitions.
    function automatic st_t model_step(input st_t c, input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [FW-1:0] f, input logic ld, input logic lt);
        st_t n = c;
        int  s;
        n.wrap = 1'b0;
        if (op == 3'd1 || op == 3'd2) begin
            s = int'(c.pc) + ((op == 3'd1) ? 1 : 2);
            n.pc = W'(s % (1 << W));
            n.wrap = (s >= (1 << W));
        end else if (op == 3'd3 || op == 3'd4) begin
            n.pc = (op == 3'd3) ? a : W'((int'(a) + 1) % (1 << W));
            n.fif = c.ib;
            n.inh = 1'b0;
        end else if (op == 3'd5) begin
            n.pc = W'(1); n.sf = c.fif; n.fif = '0; n.ib = '0; n.inh = 1'b0;
        end
        if (lt) n.pclat = c.pc;
        if (ld && op != 3'd5) begin
            n.ib = f; n.inh = 1'b1;
        end
        return n;
    endfunction

    task automatic do_cycle(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [FW-1:0] f, input logic ld, input logic lt);
        st_t e;
        @(negedge CK);
        OP = op; IN = a; FIELD_IN = f; LD_IB = ld; LATCH = lt;
        m = model_step(m, op, a, f, ld, lt);
        sb_q.push_back(m);
        @(posedge CK);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_state(tag, e);
        end
    endtask

    initial begin
        RESET = 1'b1; OP = 3'd0; IN = '0; FIELD_IN = '0; LD_IB = 1'b0; LATCH = 1'b0;
        m = reset_state();
        #3;
        check_state("reset", m);
        #4 RESET = 1'b0;

        repeat (3) do_cycle("inc", 3'd1, W'('o7777), 3'd7, 1'b0, 1'b0);
        check_eq("inc3.PC_abs", 32'(PC), 32'o203);

        do_cycle("jmp7776", 3'd3, W'('o7776), 3'd0, 1'b0, 1'b0);
        do_cycle("skip_wrap", 3'd2, '0, 3'd0, 1'b0, 1'b0);
        check_eq("skip_wrap.abs", 32'({WRAP, PC}), 32'h1000);
        do_cycle("inc_after", 3'd1, '0, 3'd0, 1'b0, 1'b0);
        do_cycle("jmp7777", 3'd3, W'('o7777), 3'd0, 1'b0, 1'b0);
        do_cycle("inc_wrap", 3'd1, '0, 3'd0, 1'b0, 1'b0);
        do_cycle("jmp7777b", 3'd3, W'('o7777), 3'd0, 1'b0, 1'b0);
        do_cycle("skip_wrap1", 3'd2, '0, 3'd0, 1'b0, 1'b0);
        do_cycle("jms_wrap", 3'd4, W'('o7777), 3'd0, 1'b0, 1'b0);
        check_eq("jms_wrap.WRAP_abs", 32'(WRAP), 32'd0);

        do_cycle("ldib5", 3'd0, '0, 3'd5, 1'b1, 1'b0);
        do_cycle("pend1", 3'd1, '0, 3'd0, 1'b0, 1'b0);
        do_cycle("pend2", 3'd1, '0, 3'd0, 1'b0, 1'b0);
        do_cycle("jms", 3'd4, W'('o100), 3'd0, 1'b0, 1'b0);
        check_eq("jms.abs", 32'({IF, PC}), 32'({3'd5, 12'o101}));

        do_cycle("int_ldib", 3'd5, W'('o4444), 3'd3, 1'b1, 1'b0);
        check_eq("int.SF_abs", 32'(SF), 32'd5);

        do_cycle("jmp377", 3'd3, W'('o377), 3'd0, 1'b0, 1'b0);
        do_cycle("latch_jmp", 3'd3, W'('o1234), 3'd0, 1'b0, 1'b1);
        check_eq("latch.abs", 32'(PCLAT), 32'o377);
        do_cycle("jmp_ldib", 3'd3, W'('o55), 3'd2, 1'b1, 1'b1);
        do_cycle("jms_ldib", 3'd4, W'('o66), 3'd4, 1'b1, 1'b0);
        do_cycle("op6", 3'd6, W'('o77), 3'd1, 1'b0, 1'b0);
        do_cycle("op7", 3'd7, W'('o77), 3'd1, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            do_cycle("rand", 3'($urandom_range(0, 7)), W'($urandom), FW'($urandom),
                     1'($urandom), 1'($urandom));
        end

        // Asynchronous reset between edges while a field change is pending.
        do_cycle("ldib6", 3'd0, '0, 3'd6, 1'b1, 1'b0);
        #2 RESET = 1'b1;
        #1;
        m = reset_state();
        check_state("async_reset", m);
        @(posedge CK);
        #3;
        OP = 3'd0; LD_IB = 1'b0; LATCH = 1'b0;
        RESET = 1'b0;
        do_cycle("first_after_reset", 3'd1, '0, 3'd0, 1'b0, 1'b0);
        check_eq("first_after_reset.abs", 32'(PC), 32'o201);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pc_field_sequencer.md
PC_FIELD_SEQUENCER -- requirements
Module: pc_field_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the PC width in bits.
REQ-002 The block SHALL have parameter FIELD_W, default 3, giving the memory-field register width in bits.
REQ-003 The block SHALL have parameter RESET_PC, default octal 0200, giving the PC value loaded on reset.
REQ-004 The block SHALL have parameter INT_VECTOR, default 1, giving the PC value loaded on interrupt entry.
REQ-005 Port CK: input, 1 bit, clock; all state changes on the rising edge except reset.
REQ-006 Port RESET: input, 1 bit, reset, asynchronous, active-high.
REQ-007 Port OP: input, 3 bits, operation code: 0 HOLD, 1 INC, 2 SKIP, 3 JMP, 4 JMS, 5 INT; codes 6-7 behave as HOLD.
REQ-008 Port IN: input, WIDTH bits, target address for JMP/JMS.
REQ-009 Port FIELD_IN: input, FIELD_W bits, new instruction-buffer value.
REQ-010 Port LD_IB: input, 1 bit, loads IB from FIELD_IN and sets inhibit.
REQ-011 Port LATCH: input, 1 bit, captures current PC into PCLAT.
REQ-012 Port PC: output, WIDTH bits, current program counter.
REQ-013 Port PCLAT: output, WIDTH bits, latched PC copy.
REQ-014 Port IF: output, FIELD_W bits, current instruction field.
REQ-015 Port IB: output, FIELD_W bits, pending instruction-buffer field.
REQ-016 Port SF: output, FIELD_W bits, IF saved at interrupt entry.
REQ-017 Port INT_INHIBIT: output, 1 bit, high while a field change is pending.
REQ-018 Port WRAP: output, 1 bit, one-cycle flag that the last INC/SKIP wrapped the PC.

Function
REQ-019 All registers SHALL be synchronous to CK rising edge; every output SHALL be a register output with no combinational path from inputs.
REQ-020 On HOLD, PC, IF and SF SHALL keep their values.
REQ-021 On INC, PC SHALL become PC+1 modulo 2^WIDTH.
REQ-022 On SKIP, PC SHALL become PC+2 modulo 2^WIDTH.
REQ-023 On JMP, PC SHALL become IN, IF SHALL take the pre-edge IB value, and INT_INHIBIT SHALL clear.
REQ-024 On JMS, PC SHALL become IN+1 modulo 2^WIDTH, IF SHALL take the pre-edge IB value, and INT_INHIBIT SHALL clear.
REQ-025 On INT, PC SHALL become INT_VECTOR, SF SHALL take the pre-edge IF, IF and IB SHALL become 0, and INT_INHIBIT SHALL clear.
REQ-026 WRAP SHALL be 1 for exactly the cycle after an INC or SKIP whose unwrapped sum is at least 2^WIDTH, and 0 otherwise, including after a JMS wrap.
REQ-027 Wrap cases: INC from all-ones gives 0; SKIP from all-ones-minus-1 gives 0; SKIP from all-ones gives 1; each of these sets WRAP.
REQ-028 When LD_IB is high, IB SHALL become FIELD_IN and INT_INHIBIT SHALL set, unless OP is INT.
REQ-029 When LD_IB is high together with JMP or JMS, IF SHALL take the old IB, IB SHALL take FIELD_IN, and INT_INHIBIT SHALL end at 1.
REQ-030 When OP is INT, INT SHALL take priority over LD_IB: IB SHALL become 0, INT_INHIBIT SHALL become 0, and FIELD_IN SHALL be ignored.
REQ-031 When LATCH is high at an edge, PCLAT SHALL take the pre-edge PC; otherwise PCLAT SHALL hold.
REQ-032 When LATCH is high together with any OP, PCLAT SHALL receive the old PC, never the updated one.
REQ-033 IN SHALL be ignored for all OP values other than JMP and JMS.

Reset
REQ-034 While RESET is high, independent of CK: PC SHALL be RESET_PC, PCLAT SHALL be 0, IF, IB and SF SHALL be 0, and INT_INHIBIT and WRAP SHALL be 0.
REQ-035 A RESET asserted mid-operation SHALL discard any pending IB change.
REQ-036 The first edge after RESET deasserts SHALL execute OP normally.

Verification
REQ-037 Reset then 3x INC -> PC goes 0200, 0201, 0202, 0203 (octal); IF=0; WRAP stays 0.
REQ-038 PC=7776 octal, then SKIP -> PC=0000 and WRAP=1 for one cycle; then INC -> PC=0001 and WRAP=0.
REQ-039 LD_IB with FIELD_IN=5, then INC, INC, then JMS with IN=0100 -> IB=5, INT_INHIBIT=1 until the JMS edge; after the JMS edge IF=5, PC=0101, INT_INHIBIT=0.
REQ-040 IF=5, LD_IB with FIELD_IN=3 and OP=INT in the same cycle -> PC=0001, SF=5, IF=0, IB=0, INT_INHIBIT=0.
REQ-041 PC=0377, LATCH=1 with JMP IN=1234 -> PCLAT=0377 and PC=1234.
REQ-042 RESET pulse between clock edges during a pending IB=6 -> all registers immediately at reset values; no edge required.
